// File: rtl/tlu_trigger_gen_pkg.sv
// tlu_trigger_gen_pkg
// Shared definitions for the trigger generator: coincidence mode encodings
// and the record layout helpers (words per record as a function of N_IN).
// A record is: ceil(N_IN/2) LE words, 4 timestamp words, 2 trigger-ID words,
// least significant word first.
package tlu_trigger_gen_pkg;

  typedef enum logic [1:0] {
    MODE_AND     = 2'd0,
    MODE_OR      = 2'd1,
    MODE_MAJ     = 2'd2,
    MODE_AND_ALT = 2'd3
  } mode_e;

  localparam int TS_WORDS = 4;
  localparam int ID_WORDS = 2;

  function automatic int le_words(input int n_in);
    return (n_in + 1) / 2;
  endfunction

  function automatic int rec_words(input int n_in);
    return le_words(n_in) + TS_WORDS + ID_WORDS;
  endfunction

endpackage

// File: rtl/tlu_trigger_gen_if.sv
// tlu_trigger_gen_if
// Record word stream, valid/ready handshake.
//   WORD_DATA  : 16-bit record word (driven by master)
//   WORD_VALID : word valid (driven by master)
//   WORD_READY : consumer accepts the word (driven by slave)
// master = trigger generator, slave = consumer.
interface tlu_trigger_gen_if;
  logic [15:0] WORD_DATA;
  logic        WORD_VALID;
  logic        WORD_READY;

  modport master (output WORD_DATA, output WORD_VALID, input WORD_READY);
  modport slave  (input WORD_DATA, input WORD_VALID, output WORD_READY);
endinterface

// File: rtl/tlu_record_fifo.sv
// tlu_record_fifo
// Single-clock FIFO holding whole trigger records.
//   clk, rst : clock, synchronous active-high reset (pointers only)
//   wr_en    : push request; accepted when not full, or when a pop happens
//              in the same cycle (the pop frees the slot)
//   wr_data  : record to push
//   rd_en    : pop request (ignored when empty)
//   rd_data  : record at the head (combinational)
//   full     : DEPTH records stored
//   empty    : no record stored
module tlu_record_fifo import tlu_trigger_gen_pkg::*; #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/tlu_trigger_gen.sv
// tlu_trigger_gen
// Beam-trigger coincidence and trigger generator. Enabled input channels are
// combined (AND / OR / MAJORITY, with a leading-edge window), the coincidence
// is registered twice and its rising edge fires a trigger when all DUT ready
// inputs are high and VETO is low. Each fired trigger queues a record
// (LE bytes, timestamp, trigger ID) that is streamed out as 16-bit words.
//
// Ports:
//   SYS_CLK, SYS_RST        : clock, synchronous active-high reset
//   START                   : clears run counters, prescaler and timestamp
//   CH_VALID, CH_LE_REL     : per-channel hit valid and relative LE byte
//   TEST_PULSE, VETO, READY : forced coincidence, block, DUT ready inputs
//   CONF_*                  : channel enable, mode, majority threshold,
//                             LE window, prescale divisor minus one
//   TRIG, TRIG_ID, TRIG_LE  : trigger pulse, current ID, MAX_LE low nibble
//   rec_bus                 : record word stream (valid/ready)
//   SKIP_CNT, LOST_CNT,
//   PRESC_CNT, TIME_STAMP   : statistics and free-running timestamp
//
// Build option: define TLU_TRIGGER_GEN_PRESCALER_EN to enable the prescaler;
// without it every unblocked edge fires and PRESC_CNT reads 0.
module tlu_trigger_gen import tlu_trigger_gen_pkg::*; #(
  parameter int N_IN      = 4,
  parameter int N_OUT     = 6,
  parameter int DEPTH     = 8,
  parameter int LE_OFFSET = 43
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RST,
  input  logic              START,
  input  logic [N_IN-1:0]   CH_VALID,
  input  logic [8*N_IN-1:0] CH_LE_REL,
  input  logic              TEST_PULSE,
  input  logic              VETO,
  input  logic [N_OUT-1:0]  READY,
  input  logic [N_IN-1:0]   CONF_EN_INPUT,
  input  logic [1:0]        CONF_MODE,
  input  logic [3:0]        CONF_MIN_HITS,
  input  logic [4:0]        CONF_MAX_LE_DISTANCE,
  input  logic [15:0]       CONF_PRESCALE,
  output logic              TRIG,
  output logic [31:0]       TRIG_ID,
  output logic [3:0]        TRIG_LE,
  tlu_trigger_gen_if.master rec_bus,
  output logic [31:0]       SKIP_CNT,
  output logic [7:0]        LOST_CNT,
  output logic [31:0]       PRESC_CNT,
  output logic [63:0]       TIME_STAMP
);

  localparam int LE_W      = le_words(N_IN);
  localparam int REC_WORDS = rec_words(N_IN);
  localparam int REC_W     = REC_WORDS * 16;
  localparam int WCW       = $clog2(REC_WORDS);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(REC_WORDS - 1);
  localparam logic [7:0]     LE_OFF8   = LE_OFFSET[7:0];

  logic [7:0]        le_min;
  logic [7:0]        le_max;
  logic [7:0]        le_span;
  logic [3:0]        hit_cnt;
  logic [N_IN-1:0]   valid_en;
  logic              mode_ok;
  logic              win_ok;
  logic              coinc;
  logic              coinc_p1;
  logic              coinc_p2;
  logic              edge_det;
  logic              blocked;
  logic              presc_acc;
  logic              fire;
  logic [31:0]       trig_id;
  logic [31:0]       skip_cnt;
  logic [7:0]        lost_cnt;
  logic [63:0]       ts;
  logic [REC_W-1:0]  rec_din;
  logic [REC_W-1:0]  rec_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic [WCW-1:0]    word_cnt;
  logic [15:0]       rec_word [REC_WORDS];

  // Leading-edge extremes and hit count over the enabled channels
  always_comb begin
    le_min  = 8'hFF;
    le_max  = 8'h00;
    hit_cnt = 4'd0;
    for (int k = 0; k < N_IN; k++) begin
      if (CONF_EN_INPUT[k]) begin
        if (CH_LE_REL[8*k +: 8] < le_min) le_min = CH_LE_REL[8*k +: 8];
        if (CH_LE_REL[8*k +: 8] > le_max) le_max = CH_LE_REL[8*k +: 8];
        if (CH_VALID[k]) hit_cnt = hit_cnt + 4'd1;
      end
    end
  end

  assign valid_en = CH_VALID & CONF_EN_INPUT;
  assign le_span  = le_max - le_min;
  assign win_ok   = le_span < {3'b000, CONF_MAX_LE_DISTANCE};

  always_comb begin
    case (mode_e'(CONF_MODE))
      MODE_OR:  mode_ok = |valid_en;
      MODE_MAJ: mode_ok = hit_cnt >= CONF_MIN_HITS;
      default:  mode_ok = (valid_en == CONF_EN_INPUT);
    endcase
  end

  assign coinc   = (mode_ok & win_ok & (|CONF_EN_INPUT)) | TEST_PULSE;
  assign TRIG_LE = le_max[3:0];

  // Stage p1/p2: coincidence registered twice for edge detection
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      coinc_p1 <= 1'b0;
      coinc_p2 <= 1'b0;
    end else begin
      coinc_p1 <= coinc;
      coinc_p2 <= coinc_p1;
    end
  end

  assign edge_det = coinc_p1 & ~coinc_p2;
  assign blocked  = ~(&READY) | VETO;

`ifdef TLU_TRIGGER_GEN_PRESCALER_EN
  logic [15:0] presc_q;
  logic [31:0] presc_cnt;
  logic        presc_hit;

  assign presc_hit = (presc_q == CONF_PRESCALE);
  assign presc_acc = presc_hit;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST || START) begin
      presc_q   <= 16'd0;
      presc_cnt <= 32'd0;
    end else if (edge_det && !blocked) begin
      if (presc_hit) begin
        presc_q <= 16'd0;
      end else begin
        presc_q   <= presc_q + 16'd1;
        presc_cnt <= presc_cnt + 32'd1;
      end
    end
  end

  assign PRESC_CNT = presc_cnt;
`else
  logic unused_presc;
  assign unused_presc = ^CONF_PRESCALE;
  assign presc_acc    = 1'b1;
  assign PRESC_CNT    = 32'd0;
`endif

  // Gated by reset so TRIG is low during the reset cycle itself
  assign fire = edge_det & ~blocked & presc_acc & ~SYS_RST;
  assign TRIG = fire;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST || START) begin
      trig_id  <= 32'd0;
      skip_cnt <= 32'd0;
      ts       <= 64'd1;
    end else begin
      if (fire) trig_id <= trig_id + 32'd1;
      if (edge_det && blocked) skip_cnt <= skip_cnt + 32'd1;
      if (ts != '1) ts <= ts + 64'd1;
    end
  end

  // A full FIFO only drops the record if no pop frees a slot this cycle
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      lost_cnt <= 8'd0;
    end else if (fire && fifo_full && !pop && lost_cnt != 8'hFF) begin
      lost_cnt <= lost_cnt + 8'd1;
    end
  end

  assign TRIG_ID    = trig_id;
  assign SKIP_CNT   = skip_cnt;
  assign LOST_CNT   = lost_cnt;
  assign TIME_STAMP = ts;

  always_comb begin
    rec_din = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (CONF_EN_INPUT[k]) rec_din[8*k +: 8] = CH_LE_REL[8*k +: 8] + LE_OFF8;
    end
    rec_din[LE_W*16 +: 64]      = ts;
    rec_din[LE_W*16 + 64 +: 32] = trig_id;
  end

  tlu_record_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (SYS_CLK),
    .rst     (SYS_RST),
    .wr_en   (fire),
    .wr_data (rec_din),
    .rd_en   (pop),
    .rd_data (rec_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    for (int w = 0; w < REC_WORDS; w++) rec_word[w] = rec_dout[16*w +: 16];
  end

  assign rec_bus.WORD_VALID = ~fifo_empty;
  assign rec_bus.WORD_DATA  = rec_word[word_cnt];
  assign pop = ~fifo_empty & rec_bus.WORD_READY & (word_cnt == LAST_WORD);

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      word_cnt <= '0;
    end else if (!fifo_empty && rec_bus.WORD_READY) begin
      word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
    end
  end

endmodule
